// File: rtl/cache_refill_ctrl_if.sv
// Cache-side miss request, backing-memory read port and refill write port
// of the line refill controller.
interface cache_refill_ctrl_if #(
    parameter int WORDS_PER_LINE = 4
);
    localparam int IW = $clog2(WORDS_PER_LINE);

    logic          miss_req;
    logic [31:0]   miss_addr;
    logic          busy;
    logic          mem_req;
    logic [31:0]   mem_addr;
    logic          mem_ready;
    logic [31:0]   mem_rdata;
    logic          refill_valid;
    logic [IW-1:0] refill_idx;
    logic [31:0]   refill_data;
    logic          refill_done;
    logic          refill_err;

    modport master (
        input  miss_req, miss_addr, mem_ready, mem_rdata,
        output busy, mem_req, mem_addr,
        output refill_valid, refill_idx, refill_data, refill_done, refill_err
    );

    modport slave (
        output miss_req, miss_addr, mem_ready, mem_rdata,
        input  busy, mem_req, mem_addr,
        input  refill_valid, refill_idx, refill_data, refill_done, refill_err
    );
endinterface

// File: rtl/cache_refill_ctrl.sv
// Critical-word-first cache line refill controller with per-beat timeout.
//   state | meaning
//   IDLE  | waiting for miss_req
//   FETCH | requesting beats from memory, wrapping from the critical word
//   DONE  | one-cycle line-complete pulse alongside the last refill word
//   ERR   | one-cycle abort pulse after a beat timed out
module cache_refill_ctrl #(
    parameter int WORDS_PER_LINE = 4,
    parameter int TIMEOUT        = 64
) (
    input logic               clk,
    input logic               rst_n,
    cache_refill_ctrl_if.master bus
);
    localparam int IW = $clog2(WORDS_PER_LINE);
    localparam int LW = IW + 2;
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, FETCH, DONE, ERR} state_t;

    state_t        state, state_nxt;
    logic [31:0]   line_base;
    logic [IW-1:0] crit;
    logic [IW-1:0] beat;
    logic [IW-1:0] idx;
    logic [CW-1:0] wait_cnt;
    logic          accept;
    logic          last_beat;
    logic          timeout_hit;

    // Truncation to IW bits gives the modulo-line wrap for free.
    assign idx         = crit + beat;
    assign accept      = (state == FETCH) && bus.mem_ready;
    assign last_beat   = (beat == IW'(WORDS_PER_LINE - 1));
    assign timeout_hit = (wait_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        bus.busy        = 1'b1;
        bus.mem_req     = 1'b0;
        bus.mem_addr    = 32'd0;
        bus.refill_done = 1'b0;
        bus.refill_err  = 1'b0;
        case (state)
            IDLE: begin
                bus.busy = 1'b0;
                if (bus.miss_req) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                bus.mem_req  = 1'b1;
                bus.mem_addr = line_base + {{(30 - IW){1'b0}}, idx, 2'b00};
                if (bus.mem_ready) begin
                    if (last_beat) begin
                        state_nxt = DONE;
                    end
                end else if (timeout_hit) begin
                    state_nxt = ERR;
                end
            end
            DONE: begin
                bus.refill_done = 1'b1;
                state_nxt       = IDLE;
            end
            ERR: begin
                bus.refill_err = 1'b1;
                state_nxt      = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_base        <= 32'd0;
            crit             <= '0;
            beat             <= '0;
            wait_cnt         <= '0;
            bus.refill_valid <= 1'b0;
            bus.refill_idx   <= '0;
            bus.refill_data  <= 32'd0;
        end else begin
            bus.refill_valid <= accept;
            if (state == IDLE && bus.miss_req) begin
                line_base <= {bus.miss_addr[31:LW], {LW{1'b0}}};
                crit      <= bus.miss_addr[LW-1:2];
                beat      <= '0;
                wait_cnt  <= '0;
            end
            if (accept) begin
                bus.refill_data <= bus.mem_rdata;
                bus.refill_idx  <= idx;
                beat            <= beat + IW'(1);
                wait_cnt        <= '0;
            end else if (state == FETCH) begin
                wait_cnt <= wait_cnt + CW'(1);
            end
        end
    end
endmodule
